led16_pwm_frame: RTL and testbench

- Per-LED 8-bit brightness generator that sits directly upstream of the led16 matrix driver; its ledbits output connects to led16's ledbits input.
- Holds a 16-entry duty table, written through a valid/ready port, and produces a 16-bit PWM on/off pattern.
- Double-buffered: writes land in a shadow bank and take effect atomically at a PWM period boundary, so a frame never tears.
- Replaces the top level's ad-hoc data16 assignment once multi-level brightness is needed.

---
 rtl/led16_pwm_frame.sv | 112 +++++++++++
 tb/tb_led16_pwm_frame.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/led16_pwm_frame.sv
// 16-lane PWM brightness generator feeding led16's ledbits.
// Duty writes land in a shadow bank that is copied to the active bank only at a period boundary.

module led16_pwm_lane #(
  parameter int DUTY_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              swap,
  input  logic [DUTY_W-1:0] wr_duty,
  input  logic [DUTY_W-1:0] cnt,
  output logic              led_q
);
  logic [DUTY_W-1:0] shadow_q, shadow_d;
  logic [DUTY_W-1:0] active_q, active_d;
  logic              led_d;

  always_comb begin
    shadow_d = wr_en ? wr_duty : shadow_q;
    active_d = swap ? shadow_q : active_q;
    led_d    = active_q > cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
      led_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      led_q    <= led_d;
    end
  end
endmodule

module led16_pwm_frame #(
  parameter int DUTY_W   = 8,
  parameter int PRESCALE = 188
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [3:0]        wr_addr,
  input  logic [DUTY_W-1:0] wr_duty,
  input  logic              commit,
  output logic              swap_pending,
  output logic              period_start,
  output logic [15:0]       ledbits
);
  localparam int NUM_LANES = 16;
  localparam int PS_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(PRESCALE - 1);
  // Period is 2^DUTY_W-1 steps, so the last step index is 2^DUTY_W-2.
  localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'((2 ** DUTY_W) - 2);

  logic [PS_W-1:0]      ps_q, ps_d;
  logic [DUTY_W-1:0]    cnt_q, cnt_d;
  logic                 pend_q, pend_d;
  logic                 pstart_q, pstart_d;
  logic                 tick, boundary, swap, wr_fire;
  logic [NUM_LANES-1:0] lane_wr;

  always_comb begin
    tick     = (ps_q == PS_LAST);
    ps_d     = tick ? '0 : ps_q + PS_W'(1);
    boundary = tick && (cnt_q == CNT_LAST);
    cnt_d    = cnt_q;
    if (tick) cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + DUTY_W'(1);
    swap     = boundary && pend_q;
    // A commit arriving on the boundary itself only arms the next boundary.
    pend_d   = pend_q;
    if (swap) pend_d = 1'b0;
    else if (commit && !pend_q) pend_d = 1'b1;
    pstart_d = boundary;
    wr_fire  = wr_valid && !pend_q;
    lane_wr  = '0;
    if (wr_fire) lane_wr[wr_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_q     <= '0;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      pstart_q <= 1'b0;
    end else begin
      ps_q     <= ps_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      pstart_q <= pstart_d;
    end
  end

  assign wr_ready     = !pend_q;
  assign swap_pending = pend_q;
  assign period_start = pstart_q;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    led16_pwm_lane #(.DUTY_W(DUTY_W)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_en  (lane_wr[i]),
      .swap   (swap),
      .wr_duty(wr_duty),
      .cnt    (cnt_q),
      .led_q  (ledbits[i])
    );
  end
endmodule

// File: tb/tb_led16_pwm_frame.sv
// Bench for led16_pwm_frame: a PRESCALE=1 instance checked cycle by cycle against a
// cycle-count reference model, plus a PRESCALE=188 instance for timing checks.
module tb_led16_pwm_frame;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, wr_valid, commit, wr_ready, swap_pending, period_start;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_duty;
  logic [15:0] ledbits;

  logic        b_rst_n, b_wr_valid, b_commit, b_wr_ready, b_swap_pending, b_period_start;
  logic [3:0]  b_wr_addr;
  logic [7:0]  b_wr_duty;
  logic [15:0] b_ledbits;

  led16_pwm_frame #(.DUTY_W(8), .PRESCALE(1)) u_p1 (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_duty(wr_duty), .commit(commit),
    .swap_pending(swap_pending), .period_start(period_start), .ledbits(ledbits));

  led16_pwm_frame #(.DUTY_W(8), .PRESCALE(188)) u_p188 (
    .clk(clk), .rst_n(b_rst_n), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready),
    .wr_addr(b_wr_addr), .wr_duty(b_wr_duty), .commit(b_commit),
    .swap_pending(b_swap_pending), .period_start(b_period_start), .ledbits(b_ledbits));

  int tests = 0;
  int fails = 0;
  bit done188 = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: cycle index k since reset release, step = k mod 255 (PRESCALE=1).
  int        mshadow[16];
  int        mactive[16];
  bit        mpend, mpstart;
  bit [15:0] mled;
  int        mk;
  int        hi[16];

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin mshadow[i] = 0; mactive[i] = 0; end
    mpend = 0; mpstart = 0; mled = '0; mk = 0;
  endtask

  task automatic model_edge();
    bit bnd;
    if (!rst_n) begin model_reset(); return; end
    bnd = ((mk + 1) % 255 == 0);
    for (int i = 0; i < 16; i++) mled[i] = (mactive[i] > (mk % 255));
    mpstart = bnd;
    if (bnd && mpend) begin
      for (int i = 0; i < 16; i++) mactive[i] = mshadow[i];
      mpend = 0;
    end else begin
      if (wr_valid && !mpend) mshadow[wr_addr] = int'(wr_duty);
      if (commit && !mpend) mpend = 1;
    end
    mk++;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("ledbits", ledbits, mled);
    chk("period_start", period_start, mpstart);
    chk("swap_pending", swap_pending, mpend);
    chk("wr_ready", wr_ready, !mpend);
  endtask

  task automatic wait_swap(input string name);
    int n = 0;
    while (swap_pending && n < 600) begin cyc(); n++; end
    chk(name, swap_pending, 0);
  endtask

  // Per-LED on-count over one full period beginning at a period_start.
  task automatic measure();
    int n = 0;
    while (!period_start && n < 600) begin cyc(); n++; end
    chk("measure period_start seen", period_start, 1);
    for (int i = 0; i < 16; i++) hi[i] = 0;
    repeat (255) begin
      cyc();
      for (int i = 0; i < 16; i++) if (ledbits[i]) hi[i]++;
    end
  endtask

  task automatic async_reset(input string name);
    rst_n = 1'b0;
    #1;
    chk({name, " ledbits"}, ledbits, 0);
    chk({name, " wr_ready"}, wr_ready, 1);
    chk({name, " swap_pending"}, swap_pending, 0);
    chk({name, " period_start"}, period_start, 0);
    model_reset();
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] addr;
    logic [7:0] duty;
    int         exp_high;
  } vec_t;

  initial begin : main_seq
    vec_t vt[6];
    bit [15:0] touched;
    int n;
    vt[0] = '{4'd5,  8'd128, 128};
    vt[1] = '{4'd0,  8'd0,   0};
    vt[2] = '{4'd15, 8'd255, 255};
    vt[3] = '{4'd9,  8'd1,   77};
    vt[4] = '{4'd9,  8'd77,  77};
    vt[5] = '{4'd12, 8'd1,   1};

    wr_valid = 0; commit = 0; wr_addr = '0; wr_duty = '0;
    rst_n = 1'b1;
    #1;
    async_reset("power-on reset");

    n = 0;
    do begin cyc(); n++; end while (!period_start && n < 300);
    chk("first period_start edges after release", n, 255);

    // Table: writes, commit together with the last write.
    touched = '0;
    for (int j = 0; j < 6; j++) begin
      wr_valid = 1; wr_addr = vt[j].addr; wr_duty = vt[j].duty;
      commit = (j == 5);
      touched[vt[j].addr] = 1'b1;
      cyc();
    end
    wr_valid = 0; commit = 0;
    chk("pending after commit", swap_pending, 1);
    chk("no ledbits before swap", ledbits, 0);
    wait_swap("table swap completes");
    repeat (3) begin
      measure();
      for (int j = 0; j < 6; j++) chk($sformatf("table led%0d on-count", vt[j].addr), hi[vt[j].addr], vt[j].exp_high);
      for (int i = 0; i < 16; i++) if (!touched[i]) chk($sformatf("untouched led%0d", i), hi[i], 0);
    end

    // Reset mid-period with a swap pending.
    repeat (37) cyc();
    wr_valid = 1; wr_addr = 4'd4; wr_duty = 8'd99; commit = 1;
    cyc();
    wr_valid = 0; commit = 0;
    chk("pending before mid-run reset", swap_pending, 1);
    repeat (10) cyc();
    async_reset("mid-run reset");

    // Write while pending is dropped.
    commit = 1; cyc(); commit = 0;
    chk("wr_ready low while pending", wr_ready, 0);
    wr_valid = 1; wr_addr = 4'd3; wr_duty = 8'd200; cyc(); wr_valid = 0;
    wait_swap("blocked-write swap");
    measure();
    chk("blocked write led3", hi[3], 0);
    chk("pending discarded by reset led4", hi[4], 0);
    wr_valid = 1; wr_addr = 4'd3; wr_duty = 8'd200; cyc(); wr_valid = 0;
    commit = 1; cyc(); commit = 0;
    wait_swap("rewrite swap");
    measure();
    chk("rewritten led3", hi[3], 200);

    // Commit exactly on the boundary cycle.
    wr_valid = 1; wr_addr = 4'd7; wr_duty = 8'd50; cyc(); wr_valid = 0;
    while ((mk % 255) != 254) cyc();
    commit = 1; cyc(); commit = 0;
    chk("boundary commit pending", swap_pending, 1);
    chk("boundary commit period_start", period_start, 1);
    measure();
    chk("boundary commit old duty led7", hi[7], 0);
    measure();
    chk("boundary commit new duty led7", hi[7], 50);
    chk("shadow retained led3", hi[3], 200);

    // Random traffic against the model.
    repeat (3000) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_addr  = 4'($urandom_range(0, 15));
      wr_duty  = 8'($urandom_range(0, 255));
      commit   = ($urandom_range(0, 19) == 0);
      cyc();
    end
    wr_valid = 0; commit = 0;

    n = 0;
    while (!done188 && n < 60000) begin cyc(); n++; end
    chk("prescale instance finished", done188, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : p188_seq
    int n, first, last, total, other;
    b_rst_n = 1'b0; b_wr_valid = 0; b_commit = 0; b_wr_addr = '0; b_wr_duty = '0;
    #2;
    chk("p188 reset ledbits", b_ledbits, 0);
    chk("p188 reset wr_ready", b_wr_ready, 1);
    @(posedge clk); @(posedge clk); #1;
    b_rst_n = 1'b1;
    b_wr_valid = 1; b_wr_addr = 4'd2; b_wr_duty = 8'd1;
    n = 0;
    while (n < 50000) begin
      @(posedge clk); n++; #1;
      if (n == 1) begin b_wr_valid = 0; b_commit = 1; end
      else if (n == 2) b_commit = 0;
      if (b_period_start) break;
    end
    chk("p188 first period_start edges", n, 47940);
    chk("p188 swap done at period start", b_swap_pending, 0);
    first = -1; last = -1; total = 0; other = 0;
    for (int j = 1; j <= 400; j++) begin
      @(posedge clk); #1;
      if (b_ledbits[2]) begin
        total++; last = j;
        if (first < 0) first = j;
      end
      if ((b_ledbits & 16'hFFFB) != 0) other++;
    end
    chk("p188 led2 first high offset", first, 1);
    chk("p188 led2 high count", total, 188);
    chk("p188 led2 consecutive span", last - first + 1, 188);
    chk("p188 other leds off", other, 0);
    done188 = 1'b1;
  end
endmodule
